// File: rtl/iter_divider_pkg.sv
// Shared constants and FSM encoding for the iterative signed divider.
package iter_divider_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/iter_divider_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module iter_divider_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH:0]   dvsr,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+2:0] trial;
    logic             borrow;

    // Shift the next dividend bit into the remainder, then trial-subtract.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = {1'b0, shifted} - {2'b00, dvsr};
        borrow   = trial[WIDTH+2];
        rem_next = borrow ? (WIDTH+1)'(shifted) : (WIDTH+1)'(trial);
        quo_next = {quo[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle 32-bit signed divider, fixed 33-edge latency.
// Optional remainder output enabled by defining DIV_REMAINDER_EN.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             busy
);

    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(OVF_DIVIDEND);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    // Magnitude is one bit wider so the most negative value stays exact.
    function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] ext;
        ext = {x[WIDTH-1], x};
        return x[WIDTH-1] ? -ext : ext;
    endfunction

    state_t           state, state_next;
    logic             load, fin;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem, rem_next, dvsr;
    logic [WIDTH-1:0] quo, quo_next;
    logic             q_neg, div_zero, ovf;
`ifdef DIV_REMAINDER_EN
    logic             a_neg;
    logic [WIDTH-1:0] a_hold;
`endif

    iter_divider_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .dvsr     (dvsr),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A start strobe in any state (re)launches; it also suppresses FIN.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        fin        = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_DIV) begin
                    load       = 1'b1;
                    state_next = ITER;
                end
            end
            ITER: begin
                if (ctrl_DIV) begin
                    load       = 1'b1;
                    state_next = ITER;
                end else if (cnt == LAST) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                if (ctrl_DIV) begin
                    load       = 1'b1;
                    state_next = ITER;
                end else begin
                    fin        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            q_neg    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else if (load) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= WIDTH'(mag(data_operandA));
            dvsr     <= mag(data_operandB);
            q_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= ~|data_operandB;
            ovf      <= (data_operandA == MIN_NEG) && (&data_operandB);
        end else if (state == ITER) begin
            cnt      <= cnt + CNT_W'(1);
            rem      <= rem_next;
            quo      <= quo_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= fin;
            if (load) begin
                busy <= 1'b1;
            end else if (fin) begin
                busy           <= 1'b0;
                data_exception <= div_zero | ovf;
                if (div_zero)  data_result <= '0;
                else if (ovf)  data_result <= MIN_NEG;
                else if (q_neg) data_result <= -quo;
                else           data_result <= quo;
            end
        end
    end

`ifdef DIV_REMAINDER_EN
    // Remainder takes the dividend's sign; div-by-zero returns the dividend.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_neg          <= 1'b0;
            a_hold         <= '0;
            data_remainder <= '0;
        end else if (load) begin
            a_neg  <= data_operandA[WIDTH-1];
            a_hold <= data_operandA;
        end else if (fin) begin
            if (div_zero)   data_remainder <= a_hold;
            else if (ovf)   data_remainder <= '0;
            else if (a_neg) data_remainder <= -WIDTH'(rem);
            else            data_remainder <= WIDTH'(rem);
        end
    end
`endif

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider against a plain-arithmetic reference.
// Exercises the DIV_REMAINDER_EN remainder port when that macro is defined.
module tb_iter_divider;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;
`ifdef DIV_REMAINDER_EN
    logic [31:0] data_remainder;
`endif

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] prev_q, prev_r;
    logic        prev_e;

    iter_divider dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
`ifdef DIV_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: signed integer division with truncation toward zero.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic e);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'd0; r = a; e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; e = 1'b1;
        end else begin
            q = 32'(sa / sb); r = 32'(sa % sb); e = 1'b0;
        end
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
    endtask

    // Check outputs hold through E1..E32, then the E33 result and E34 pulse end.
    task automatic finish_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        logic        e;
        logic        ok;
        model(a, b, q, r, e);
        ok = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY !== 1'b0 || busy !== 1'b1 ||
                data_result !== prev_q || data_exception !== prev_e) ok = 1'b0;
        end
        chk({tag, ".hold"}, 32'(ok), 32'd1);
        @(posedge clock);
        #1;
        chk({tag, ".rdy"},  32'(data_resultRDY), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".q"},    data_result, q);
        chk({tag, ".exc"},  32'(data_exception), 32'(e));
`ifdef DIV_REMAINDER_EN
        chk({tag, ".rem"},  data_remainder, r);
`endif
        prev_q = q;
        prev_e = e;
        prev_r = r;
        @(posedge clock);
        #1;
        chk({tag, ".rdy_off"}, 32'(data_resultRDY), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        issue(a, b);
        chk({tag, ".busy_on"}, 32'(busy), 32'd1);
        finish_op(tag, a, b);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        ok;
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        prev_q = '0; prev_e = 1'b0; prev_r = '0;
        #12;
        chk("rst.q",    data_result, 32'd0);
        chk("rst.exc",  32'(data_exception), 32'd0);
        chk("rst.rdy",  32'(data_resultRDY), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_op("d7_2",    32'd7, 32'd2);
        run_op("dm7_2",   32'hFFFF_FFF9, 32'd2);
        run_op("d5_0",    32'd5, 32'd0);
        run_op("d100_m10", 32'd100, 32'hFFFF_FFF6);
        run_op("ovf",     32'h8000_0000, 32'hFFFF_FFFF);
        run_op("min_1",   32'h8000_0000, 32'd1);
        run_op("d7_2b",   32'd7, 32'd2);

        // Restart at E10 aborts 9/3 without a pulse.
        issue(32'd9, 32'd3);
        ok = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY !== 1'b0) ok = 1'b0;
        end
        chk("abort.no_rdy", 32'(ok), 32'd1);
        issue(32'd20, 32'd4);
        finish_op("abort.d20_4", 32'd20, 32'd4);

        // Restart on the FIN edge: no pulse, previous result kept.
        issue(32'd77, 32'd7);
        repeat (32) @(posedge clock);
        issue(32'd30, 32'hFFFF_FFFD);
        chk("finrst.rdy",  32'(data_resultRDY), 32'd0);
        chk("finrst.q",    data_result, prev_q);
        chk("finrst.busy", 32'(busy), 32'd1);
        finish_op("finrst.d30_m3", 32'd30, 32'hFFFF_FFFD);

        // Asynchronous reset mid-iteration.
        issue(32'd50, 32'd5);
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.q",    data_result, 32'd0);
        chk("arst.exc",  32'(data_exception), 32'd0);
        chk("arst.rdy",  32'(data_resultRDY), 32'd0);
        chk("arst.busy", 32'(busy), 32'd0);
        prev_q = '0; prev_e = 1'b0; prev_r = '0;
        @(negedge clock);
        reset = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        chk("arst.quiet", 32'(ok), 32'd1);
        run_op("d8_2", 32'd8, 32'd2);

        // Randomized operands, mixing small and full-range divisors.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = 32'($signed(32'($urandom_range(0, 40)) - 32'd20));
                2: rb = 32'($urandom_range(1, 65535));
                default: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            endcase
            if (i == 5) ra = 32'h8000_0000;
            run_op("rand", ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
